if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the pipelined RISC-V core. Drives the instruction-fetch side
//  of the IF/ID interface (pc_out -> pc_in, instruction_fetched -> instruction_fetched).
//  Holds the PC and requests words from instruction memory over a req/gnt/rvalid handshake.
//  Buffers returned words in a small in-order queue; honours stall from hazard unit and
//  redirect from EX (taken branch/jump).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  BUF_DEPTH  2              fetch-queue slots (= max outstanding + buffered), power of 2, >=2
//  NOP_INSTR  32'h0000_0013  word driven on instruction_fetched when fetch_valid=0 (addi x0,x0,0)
// PORTS
//  clk                  in   1   clock, all state on posedge
//  reset                in   1   synchronous, active-high
//  imem_req             out  1   fetch request valid
//  imem_addr            out  32  fetch address (word aligned)
//  imem_gnt             in   1   request accepted this cycle (req&gnt = handshake)
//  imem_rvalid          in   1   read data valid; responses in request order, >=1 cycle after gnt
//  imem_rdata           in   32  instruction word
//  redirect             in   1   taken branch/jump; flush and restart fetch
//  redirect_pc          in   32  new PC; bits [1:0] forced to 0
//  stall                in   1   IF/ID hold; head entry must not be consumed
//  pc_out               out  32  PC of presented instruction
//  instruction_fetched  out  32  presented instruction
//  fetch_valid          out  1   pc_out/instruction_fetched hold a real fetched instruction
// BEHAVIOUR
//  - Reset (sync, takes priority over everything): pc<=RESET_PC; queue empty; drop_cnt<=0;
//    imem_req=0, fetch_valid=0, pc_out=0, instruction_fetched=NOP_INSTR while reset high.
//  - Queue: BUF_DEPTH slots, each {pc, instr, filled}. Slot allocated at handshake
//    (req&gnt), pc written then; instr+filled written when matching rvalid arrives.
//  - imem_req = !reset & !redirect & (free slots > 0 OR head popped this cycle);
//    imem_addr = pc. The same-cycle pop/allocate gives 1 instr/cycle with 1-cycle memory.
//  - On handshake: pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0). No handshake: pc and addr held.
//  - Output: head filled -> fetch_valid=1, pc_out/instruction_fetched from head (registered,
//    no rvalid->output bypass). Else fetch_valid=0, pc_out=0, instruction_fetched=NOP_INSTR.
//  - Pop: fetch_valid & !stall. stall=1 holds all three outputs stable.
//  - Latency: gnt in cycle t, rvalid in t+1 -> fetch_valid in t+2.
//  - Redirect (priority over stall, gnt, rvalid): pc<=redirect_pc; all slots invalidated;
//    drop_cnt <= number of granted-but-unreturned requests (incl. one granted this cycle,
//    minus one returning this cycle). imem_req=0 in redirect cycle; fetch from new pc next cycle.
//  - drop_cnt>0: next rvalid discarded, drop_cnt-=1; no slot written. New requests may issue
//    meanwhile; their responses are placed only after drop_cnt reaches 0.
//  - rvalid with no outstanding request and drop_cnt=0: ignored.
//  - Outstanding+filled never exceeds BUF_DEPTH; no overflow path exists.
// TESTING
//  1 reset 3 cycles, gnt=1 -> imem_req=0 during reset; after release addr 0x0,0x4,0x8;
//    fetch_valid=0, instruction_fetched=0x00000013 until first rvalid.
//  2 1-cycle memory, rdata=0x00500093,0x00a00113,0x002081b3 -> fetch_valid from cycle 2 after
//    release, pc_out 0x0,0x4,0x8 on consecutive cycles, no bubbles.
//  3 stall=1 for 4 cycles mid-stream -> pc_out/instr frozen, imem_req=0 once 2 slots used,
//    release -> next pc_out = prior+4, no instruction lost or duplicated.
//  4 two outstanding, redirect=1 redirect_pc=0x103 -> both stale rvalids dropped, first
//    fetch_valid shows pc_out=0x100.
//  5 imem_gnt=0 for 5 cycles -> imem_addr stable, pc not advanced, fetch_valid drops to 0.
//  6 redirect + stall + rvalid same cycle -> redirect wins, rvalid dropped, next addr=redirect_pc.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC, imem req/gnt/rvalid issue, in-order fetch queue feeding IF/ID; gnt@t -> out@t+2.
// stall holds the head entry and stops requests once the queue is full; redirect flushes and drops stale returns.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_fetched,
  output logic        fetch_valid
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  // Repeated redirects can stack unreturned requests beyond one queue's worth.
  localparam int unsigned DW = CW + 4;
  localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);

  logic [31:0]          pc_q, pc_d;
  logic [AW-1:0]        head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
  logic [CW-1:0]        cnt_q, cnt_d, outs_q, outs_d;
  logic [DW-1:0]        drop_q, drop_d;
  logic [31:0]          slot_pc_q  [BUF_DEPTH];
  logic [31:0]          slot_pc_d  [BUF_DEPTH];
  logic [31:0]          slot_ins_q [BUF_DEPTH];
  logic [31:0]          slot_ins_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] slot_fill_q, slot_fill_d;

  logic          pop, hs, ret;
  logic [DW-1:0] unret;

  always_comb begin
    fetch_valid         = !reset && slot_fill_q[head_q];
    pc_out              = fetch_valid ? slot_pc_q[head_q] : 32'h0;
    instruction_fetched = fetch_valid ? slot_ins_q[head_q] : NOP_INSTR;
    pop                 = fetch_valid && !stall;
    imem_req            = !reset && !redirect && ((cnt_q != DEPTH) || pop);
    imem_addr           = pc_q;
    hs                  = imem_req && imem_gnt;
    ret                 = imem_rvalid && (drop_q == '0) && (outs_q != '0);
    unret               = drop_q + DW'(outs_q);
  end

  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fptr_d      = fptr_q;
    cnt_d       = cnt_q;
    outs_d      = outs_q;
    drop_d      = drop_q;
    slot_pc_d   = slot_pc_q;
    slot_ins_d  = slot_ins_q;
    slot_fill_d = slot_fill_q;
    if (redirect) begin
      pc_d        = redirect_pc & ~32'h3;
      head_d      = '0;
      tail_d      = '0;
      fptr_d      = '0;
      cnt_d       = '0;
      outs_d      = '0;
      slot_fill_d = '0;
      drop_d      = unret - DW'(imem_rvalid && (unret != '0));
    end else begin
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - DW'(1);
      end else if (ret) begin
        slot_ins_d[fptr_q]  = imem_rdata;
        slot_fill_d[fptr_q] = 1'b1;
        fptr_d              = fptr_q + AW'(1);
      end
      if (hs) begin
        slot_pc_d[tail_q]   = pc_q;
        slot_fill_d[tail_q] = 1'b0;
        tail_d              = tail_q + AW'(1);
        pc_d                = pc_q + 32'd4;
      end
      if (pop) begin
        slot_fill_d[head_q] = 1'b0;
        head_d              = head_q + AW'(1);
      end
      cnt_d  = cnt_q + CW'(hs) - CW'(pop);
      outs_d = outs_q + CW'(hs) - CW'(ret);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      fptr_q      <= '0;
      cnt_q       <= '0;
      outs_q      <= '0;
      drop_q      <= '0;
      slot_pc_q   <= '{default: '0};
      slot_ins_q  <= '{default: '0};
      slot_fill_q <= '0;
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fptr_q      <= fptr_d;
      cnt_q       <= cnt_d;
      outs_q      <= outs_d;
      drop_q      <= drop_d;
      slot_pc_q   <= slot_pc_d;
      slot_ins_q  <= slot_ins_d;
      slot_fill_q <= slot_fill_d;
    end
  end

endmodule
